// File: rtl/sr_based_t_ff.sv
// Bank of independent toggle flip-flops, each built from an SR storage cell
// driven by T-to-SR excitation logic (s = t & ~q, r = t & q).
module sr_based_t_ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    // Excitation nets; kept as named signals so they can be probed hierarchically.
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;

    assign s = t & ~q;
    assign r = t & q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                // s=r=1 cannot come from the excitation logic; it holds so no X can appear.
                case ({s[i], r[i]})
                    2'b10:   q[i] <= 1'b1;
                    2'b01:   q[i] <= 1'b0;
                    default: q[i] <= q[i];
                endcase
            end
        end
    end

    assign qb = ~q;

endmodule

// File: tb/tb_sr_based_t_ff.sv
// Scoreboard bench: a 1-bit and a 4-bit instance share clk/rst; the driver
// queues hand-computed q values per edge and a monitor checks them after each edge.
module tb_sr_based_t_ff;

    logic       clk;
    logic       rst;
    logic [0:0] t1;
    logic [0:0] q1;
    logic [0:0] qb1;
    logic [3:0] t4;
    logic [3:0] q4;
    logic [3:0] qb4;

    logic [0:0] exp1_q[$];
    logic [3:0] exp4_q[$];

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  seen_reset = 1'b0;

    sr_based_t_ff #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .t   (t1),
        .q   (q1),
        .qb  (qb1)
    );

    sr_based_t_ff #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .t   (t4),
        .q   (q4),
        .qb  (qb4)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic rv, input logic t1v, input logic e1,
                        input logic [3:0] t4v, input logic [3:0] e4);
        @(negedge clk);
        rst = rv;
        t1  = t1v;
        t4  = t4v;
        exp1_q.push_back(e1);
        exp4_q.push_back(e4);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        #1;
        if (exp1_q.size() > 0) begin
            logic [0:0] e;
            e = exp1_q.pop_front();
            check("q1", {3'b0, q1}, {3'b0, e});
            check("qb1", {3'b0, qb1}, {3'b0, ~e});
        end
        if (exp4_q.size() > 0) begin
            logic [3:0] e;
            e = exp4_q.pop_front();
            check("q4", q4, e);
            check("qb4", qb4, ~e);
        end
    end

    // ---------------- invariants ----------------
    always @(negedge clk) begin
        if (seen_reset) begin
            check("inv_sr1", {3'b0, dut1.s & dut1.r}, 4'b0);
            check("inv_sr4", dut4.s & dut4.r, 4'b0);
            check("inv_qb1", {3'b0, qb1 ^ q1}, 4'b0001);
            check("inv_qb4", qb4 ^ q4, 4'b1111);
            check("inv_x", {3'b0, $isunknown({q1, q4})}, 4'b0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        t1  = 1'b1;
        t4  = 4'hf;
        #2;
        rst = 1'b1;
        seen_reset = 1'b1;
        #1;
        // Clear happens before any clock edge.
        check("async_rst_q1", {3'b0, q1}, 4'b0);
        check("async_rst_qb1", {3'b0, qb1}, 4'b0001);
        check("async_rst_q4", q4, 4'b0);

        // Held in reset with toggle requested: no movement.
        repeat (3) step(1'b1, 1'b1, 1'b0, 4'hf, 4'h0);

        // Release, then t = 0,1,0,1,1,0 -> q = 0,1,1,0,1,1.
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        step(1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
        step(1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        step(1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
        step(1'b0, 1'b0, 1'b1, 4'h0, 4'h0);

        // Bring q to 0, then continuous toggle for 8 edges.
        step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 4'h0, 4'h0);
        end

        // q = 1, then asynchronous reset between edges.
        step(1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
        @(negedge clk);
        t1  = 1'b1;
        rst = 1'b1;
        #1;
        check("midrun_rst_q1", {3'b0, q1}, 4'b0);
        check("midrun_rst_qb1", {3'b0, qb1}, 4'b0001);
        #1;
        rst = 1'b0;
        exp1_q.push_back(1'b1);
        exp4_q.push_back(4'h0);

        // Multi-bit: hold q1, toggle patterns on the 4-bit bank.
        step(1'b0, 1'b0, 1'b1, 4'b1010, 4'b1010);
        step(1'b0, 1'b0, 1'b1, 4'b0110, 4'b1100);
        step(1'b0, 1'b0, 1'b1, 4'b1111, 4'b0011);
        step(1'b0, 1'b0, 1'b1, 4'b0101, 4'b0110);

        // A pulse on t between edges must not be captured.
        @(negedge clk);
        t1 = 1'b1;
        t4 = 4'hf;
        #1;
        t1 = 1'b0;
        t4 = 4'h0;
        exp1_q.push_back(1'b1);
        exp4_q.push_back(4'b0110);

        // Hold with t low.
        step(1'b0, 1'b0, 1'b1, 4'h0, 4'b0110);

        repeat (2) @(posedge clk);
        #2;
        check("queue1_drained", exp1_q.size() == 0 ? 4'd1 : 4'd0, 4'd1);
        check("queue4_drained", exp4_q.size() == 0 ? 4'd1 : 4'd0, 4'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_based_t_ff.md
Name: sr_based_t_ff

Overview:
- Toggle (T) flip-flop bank built by converting an SR flip-flop.
- Each bit has an SR storage cell plus excitation logic: S = T & ~Q, R = T & Q.
- Result per bit: T=1 toggles the output on the rising clock edge; T=0 holds it.
- Used as a counter/divider primitive and as the reference cell for flip-flop conversion exercises.

Parameters:
- WIDTH, 1, number of independent T flip-flop bits (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high; clears all state.
- t  input  WIDTH  toggle request per bit.
- q  output  WIDTH  registered flip-flop state.
- qb  output  WIDTH  complement of q (always ~q, combinational from the register).

Behaviour:
- Reset:
  - rst=1 forces q=0 and qb=all-ones immediately, independent of clk.
  - Outputs hold while rst stays high.
  - Release of rst takes effect on the next rising clk edge after deassertion.
- Excitation (combinational, per bit i):
  - s[i] = t[i] & ~q[i]
  - r[i] = t[i] & q[i]
- SR cell, updated on each rising clk edge when rst=0:
  - s=0, r=0: hold.
  - s=1, r=0: q becomes 1.
  - s=0, r=1: q becomes 0.
  - s=1, r=1: never produced by the excitation logic. The SR cell must still define it as hold, so there is no X propagation.
- Net per-bit function: q_next = q ^ t.
  - Latency: 1 clock from t sampled to q updated.
  - No combinational path from t to q.
- Bits are fully independent; there is no carry or interaction between bits.
- t is sampled only at the rising clk edge. Glitches between edges have no effect.
- Toggle with t held high: q alternates every edge, so q is clk/2.
- Reset mid-operation:
  - Asserting rst between edges clears q at once; the pending toggle is discarded.
  - If rst deasserts before an edge with t=1, that edge toggles q from 0 to 1.
- Simultaneous rst and clk edge: rst wins, q=0.
- Invariant: qb == ~q at all times after reset; s & r == 0 at all times.
- Internal s/r nets are not exposed; they must be observable hierarchically for verification.

Test Plan:
- Reset check (WIDTH=1):
  - Stimulus: assert rst with t=1 while clk runs.
  - Required: q=0 and qb=1 hold during reset; no toggling.
- Directed sequence (WIDTH=1), clk period 10 ns, edges at 5, 15, 25, 35, 45, 55 ns:
  - Stimulus: after reset, apply t at the six edges = 0, 1, 0, 1, 1, 0.
  - Required q after each edge = 0, 1, 1, 0, 1, 1.
- Continuous toggle:
  - Stimulus: t=1 for 8 edges starting from q=0.
  - Required: q = 1, 0, 1, 0, 1, 0, 1, 0; qb is always the inverse.
- Asynchronous reset mid-run:
  - Stimulus: q=1, assert rst midway between edges.
  - Required: q drops to 0 before the next edge.
  - Then: deassert with t=1; the next edge gives q=1.
- Multi-bit (WIDTH=4):
  - Stimulus: from q=4'b0000, apply t=4'b1010, then 4'b0110, then 4'b1111.
  - Required: q=4'b1010, then 4'b1100, then 4'b0011.
- Invariant assertions on every cycle of all tests:
  - s & r == 0.
  - qb == ~q.
  - No X on q after the first reset.
